seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, is the maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, is the width of the match counter and of the target threshold.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  is the reset; it SHALL be synchronous and active-low.
REQ-005 cfg_we  in  1  is the configuration load strobe.
REQ-006 cfg_pattern  in  PAT_W  is the pattern; bit 0 is the most recently received bit.
REQ-007 cfg_len  in  4  is the pattern length used for matching.
REQ-008 cfg_overlap  in  1  selects the mode: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 cfg_target  in  CNT_W  is the match count that terminates a run; 0 = never terminate.
REQ-010 start  in  1  starts a run.
REQ-011 stop  in  1  aborts a run.
REQ-012 in_valid  in  1  marks in_seq as valid in the current cycle.
REQ-013 in_seq  in  1  is the serial data bit.
REQ-014 seq_detected  out  1  is a registered one-cycle match pulse (Moore-style).
REQ-015 match_count  out  CNT_W  is the number of matches counted in the current or last run.
REQ-016 done  out  1  is a one-cycle pulse when the target count is reached.
REQ-017 busy  out  1  is high while in the RUN state.
REQ-018 state  out  2  shows the FSM state: IDLE=0, RUN=1, DONE=2.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE; encoding 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-020 In IDLE or DONE, cfg_we=1 SHALL latch cfg_pattern, cfg_len, cfg_overlap and cfg_target into shadow registers.
REQ-021 In RUN, cfg_we SHALL be ignored.
REQ-022 A latched cfg_len of 0 SHALL act as 1, and a value >PAT_W SHALL act as PAT_W.
REQ-023 In IDLE or DONE, start=1 SHALL clear the shift register, fill counter, match_count and seq_detected, and SHALL enter RUN on the same edge.
REQ-024 In RUN, stop=1 SHALL enter IDLE; match_count is retained and the bit presented in that cycle is discarded.
REQ-025 When start and stop are both high, stop SHALL win in RUN and start SHALL win in IDLE or DONE.
REQ-026 In RUN with in_valid=1, in_seq SHALL shift into bit 0 of a PAT_W shift register.
REQ-027 On each accepted bit, the fill counter SHALL increment, saturating at PAT_W.
REQ-028 In RUN with in_valid=0, the shift register and fill counter SHALL hold, and seq_detected SHALL be 0 next cycle.
REQ-029 A match SHALL occur on an accepted bit when fill (including that bit) >= len and the low len bits of the updated shift register equal the low len bits of the pattern.
REQ-030 On a match, seq_detected SHALL be 1 for exactly the one cycle following the accepting edge; it is 0 otherwise.
REQ-031 On a match, match_count SHALL increment on the accepting edge, saturating at 2^CNT_W-1.
REQ-032 In non-overlap mode, a match SHALL reset fill to 0, so the next match needs len fresh bits.
REQ-033 In overlap mode, fill SHALL be unaffected by a match.
REQ-034 When cfg_target!=0 and a match makes match_count equal cfg_target, the FSM SHALL enter DONE on that edge and done SHALL be 1 for the following cycle only.
REQ-035 In DONE, in_valid SHALL be ignored and match_count held until start or reset.
REQ-036 busy SHALL equal (state==RUN).
REQ-037 All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-038 When rst=0 at a rising edge, the state SHALL become IDLE and seq_detected, done, busy, match_count, fill and the shift register SHALL become 0.
REQ-039 Reset SHALL set the shadow config to pattern=0, len=PAT_W, overlap=0, target=0.
REQ-040 Reset SHALL take priority over every other input, including when asserted mid-run.
REQ-041 Reset SHALL take effect on the edge only, with no asynchronous path.

Verification
REQ-042 Overlap scenario: config 1101, len=4, overlap=1, target=0; start; stream 1101101 with in_valid=1 -> seq_detected pulses after bits 4 and 7; match_count=2.
REQ-043 Non-overlap scenario: same config and stream with overlap=0 -> a single pulse after bit 4; match_count=1.
REQ-044 Target scenario: target=3, pattern 11, len=2, overlap=0; stream 111111 -> done pulses after bit 6; state=DONE; busy=0; further bits leave match_count=3.
REQ-045 Valid-gap scenario: pattern 101 with in_valid low for 5 cycles between the 1st and 2nd bit -> a match is still detected after the 3rd valid bit.
REQ-046 Stop and re-arm scenario: stop after 2 bits, then start, then stream 1101 -> the counter and shift register are cleared on start and exactly one match is seen; cfg_we pulsed during RUN leaves the config unchanged.
REQ-047 Reset scenario: rst=0 for one edge mid-run after 3 matches -> the next cycle shows state=IDLE, match_count=0, seq_detected=0 and len restored to PAT_W.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector with run control.
//
// A run is started with 'start'. While running, every bit accepted via
// in_valid/in_seq is shifted into bit 0 of a shift register. The low 'len'
// bits are compared against the latched pattern. A match produces a
// registered one-cycle seq_detected pulse and bumps a saturating match
// counter. A non-zero target ends the run in DONE with a one-cycle 'done'
// pulse. 'stop' aborts a run back to IDLE.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   cfg_we        configuration load strobe (honoured in IDLE/DONE only)
//   cfg_pattern   pattern, bit 0 = most recently received bit
//   cfg_len       pattern length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_overlap   1 = overlapping matches, 0 = non-overlapping
//   cfg_target    match count that ends a run, 0 = never
//   start, stop   run control
//   in_valid      in_seq qualifier
//   in_seq        serial data bit
//   seq_detected  one-cycle match pulse
//   match_count   matches in the current or last run
//   done          one-cycle pulse when the target is reached
//   busy          high in RUN
//   state         IDLE=0, RUN=1, DONE=2
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             in_seq,
  output logic             seq_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           cur_state, nxt_state;
  logic [PAT_W-1:0] shift_reg, shift_upd;
  logic [LEN_W-1:0] fill, fill_upd;
  logic [CNT_W-1:0] count_upd;
  logic             hit;

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_eff;
  logic             ovl_reg;
  logic [CNT_W-1:0] target_reg;

  // Length is clamped once at load time so the datapath only ever sees 1..PAT_W.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0) return LEN_W'(1);
    if (int'(l) > PAT_W) return PAT_W_L;
    return LEN_W'(l);
  endfunction

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] f);
    return (f >= PAT_W_L) ? f : f + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Candidate next values for an accepted bit, plus next-state decode.
  always_comb begin
    shift_upd = {shift_reg[PAT_W-2:0], in_seq};
    fill_upd  = sat_fill(fill);
    hit       = (fill_upd >= len_eff) &&
                (((shift_upd ^ pat_reg) & len_mask(len_eff)) == '0);
    count_upd = sat_cnt(match_count);
    nxt_state = cur_state;
    case (cur_state)
      IDLE, DONE: begin
        if (start) nxt_state = RUN;
      end
      RUN: begin
        if (stop) begin
          nxt_state = IDLE;
        end else if (in_valid && hit && (target_reg != '0) &&
                     (count_upd == target_reg)) begin
          nxt_state = DONE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state    <= IDLE;
      shift_reg    <= '0;
      fill         <= '0;
      match_count  <= '0;
      seq_detected <= 1'b0;
      done         <= 1'b0;
      pat_reg      <= '0;
      len_eff      <= PAT_W_L;
      ovl_reg      <= 1'b0;
      target_reg   <= '0;
    end else begin
      cur_state    <= nxt_state;
      seq_detected <= 1'b0;
      done         <= 1'b0;
      case (cur_state)
        IDLE, DONE: begin
          if (cfg_we) begin
            pat_reg    <= cfg_pattern;
            len_eff    <= clamp_len(cfg_len);
            ovl_reg    <= cfg_overlap;
            target_reg <= cfg_target;
          end
          if (start) begin
            shift_reg   <= '0;
            fill        <= '0;
            match_count <= '0;
          end
        end
        RUN: begin
          if (!stop && in_valid) begin
            shift_reg <= shift_upd;
            // Non-overlap mode discards history so the next match needs len fresh bits.
            fill      <= (hit && !ovl_reg) ? '0 : fill_upd;
            if (hit) begin
              match_count  <= count_upd;
              seq_detected <= 1'b1;
              done         <= (nxt_state == DONE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (cur_state == RUN);
  assign state = cur_state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a behavioural model predicts each
// cycle's outputs, pushes them to a scoreboard queue, and the entry is
// popped and compared once the DUT has registered that cycle.
module tb_seq_det_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, cfg_we, cfg_overlap, start, stop, in_valid, in_seq;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic             seq_detected, done, busy;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .in_valid(in_valid), .in_seq(in_seq),
    .seq_detected(seq_detected), .match_count(match_count), .done(done),
    .busy(busy), .state(state)
  );

  typedef struct {
    logic       sd;
    logic [7:0] cnt;
    logic       dn;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int       m_state = 0;
  int       m_cnt   = 0;
  bit [7:0] m_pat   = 0;
  int       m_len   = PAT_W;
  bit       m_ovl   = 0;
  int       m_tgt   = 0;
  bit       hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit we, input bit s, input bit p,
                      input bit v, input bit b);
    exp_t e;
    bit   hit;
    @(negedge clk);
    rst = r; cfg_we = we; start = s; stop = p; in_valid = v; in_seq = b;
    e.sd = 1'b0;
    e.dn = 1'b0;
    if (!r) begin
      m_state = 0; m_cnt = 0; m_pat = 0; m_len = PAT_W; m_ovl = 0; m_tgt = 0;
      hist.delete();
    end else if (m_state == 1) begin
      if (p) begin
        m_state = 0;
      end else if (v) begin
        hist.push_back(b);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        hit = 0;
        if (hist.size() >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 0;
        end
        if (hit) begin
          if (m_cnt < 255) m_cnt++;
          e.sd = 1'b1;
          if (!m_ovl) hist.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) begin
            m_state = 2;
            e.dn = 1'b1;
          end
        end
      end
    end else begin
      if (we) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len == 0) ? 1 : ((cfg_len > PAT_W) ? PAT_W : int'(cfg_len));
        m_ovl = cfg_overlap;
        m_tgt = cfg_target;
      end
      if (s) begin
        hist.delete();
        m_cnt   = 0;
        m_state = 1;
      end
    end
    e.cnt = 8'(m_cnt);
    e.st  = 2'(m_state);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("seq_detected", seq_detected, e.sd);
    chk("match_count", match_count, e.cnt);
    chk("done", done, e.dn);
    chk("state", state, e.st);
    chk("busy", busy, (e.st == 2'd1));
  endtask

  task automatic load_cfg(input bit [7:0] pat, input bit [3:0] len,
                          input bit ovl, input bit [7:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    step(1, 1, 0, 0, 0, 0);
  endtask

  // Streams n bits of 'bits', oldest (bits[n-1]) first.
  task automatic feed(input bit [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, 0, 0, 0, 1, bits[i]);
  endtask

  initial begin
    rst = 0; cfg_we = 0; start = 0; stop = 0; in_valid = 0; in_seq = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;

    // Reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 1);
    chk("rst_state", state, 0);

    // Overlapping: 1101101 -> two matches
    load_cfg(8'b1101, 4, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'b1101101, 7);
    chk("ovl_count", match_count, 2);
    step(1, 0, 0, 1, 0, 0);

    // Non-overlapping: same stream -> one match
    load_cfg(8'b1101, 4, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'b1101101, 7);
    chk("novl_count", match_count, 1);
    step(1, 0, 0, 1, 0, 0);

    // Target reached: 111111 with pattern 11 -> done after bit 6
    load_cfg(8'b11, 2, 0, 3);
    step(1, 0, 1, 0, 0, 0);
    feed(8'b111111, 6);
    chk("tgt_state", state, 2);
    chk("tgt_busy", busy, 0);
    feed(8'b1111, 4);
    chk("tgt_hold", match_count, 3);

    // Valid gap inside pattern 101
    load_cfg(8'b101, 3, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1);
    feed(8'b01, 2);
    chk("gap_count", match_count, 1);
    step(1, 0, 0, 1, 0, 0);

    // Stop after 2 bits, re-arm, cfg_we during RUN ignored
    load_cfg(8'b1101, 4, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'b11, 2);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    cfg_pattern = 8'h00; cfg_len = 1; cfg_overlap = 1; cfg_target = 1;
    step(1, 1, 0, 0, 0, 0);
    feed(8'b1101, 4);
    chk("rearm_count", match_count, 1);

    // start+stop: stop wins in RUN (bit discarded), start wins in IDLE
    step(1, 0, 1, 1, 1, 1);
    chk("ss_run_state", state, 0);
    step(1, 0, 1, 1, 0, 0);
    chk("ss_idle_state", state, 1);

    // Reset mid-run after 3 matches, then default len=PAT_W with pattern 0
    load_cfg(8'b1, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    load_cfg(8'b1, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'b111, 3);
    chk("pre_rst_count", match_count, 3);
    step(0, 0, 0, 0, 1, 1);
    chk("mid_rst_count", match_count, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'h00, 7);
    chk("deflen_7", match_count, 0);
    feed(8'h00, 1);
    chk("deflen_8", match_count, 1);
    step(1, 0, 0, 1, 0, 0);

    // Length clamps: 0 acts as 1, 15 acts as PAT_W
    load_cfg(8'b1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'b1, 1);
    chk("len0_count", match_count, 1);
    step(1, 0, 0, 1, 0, 0);
    load_cfg(8'hA5, 15, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    feed(8'hA5, 8);
    chk("len15_count", match_count, 1);
    step(1, 0, 0, 1, 0, 0);

    // Counter saturation
    load_cfg(8'b1, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 260; i++) step(1, 0, 0, 0, 1, 1);
    chk("sat_count", match_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
